// File: rtl/iob_regfile_sp_arb.sv
// ============================================================================
// Module      : iob_regfile_sp_arb
// Description : Round-robin arbiter and hardware clear sequencer for a
//               single-port register file shared by two requesters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module iob_regfile_sp_arb #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              req0_valid,
    input  logic              req0_we,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              req0_ready,
    output logic              req0_rvalid,
    output logic [DATA_W-1:0] req0_rdata,

    input  logic              req1_valid,
    input  logic              req1_we,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              req1_ready,
    output logic              req1_rvalid,
    output logic [DATA_W-1:0] req1_rdata,

    input  logic              clr_start,
    output logic              clr_busy,
    output logic              clr_done,

    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_addr,
    output logic [DATA_W-1:0] rf_w_data,
    input  logic [DATA_W-1:0] rf_r_data
);

    localparam logic [ADDR_W-1:0] c_LAST_ADDR = '1;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_ptr;
    logic                w_ptr_nxt;
    logic [ADDR_W-1:0]   r_cnt;
    logic [ADDR_W-1:0]   w_cnt_nxt;
    logic                r_done;
    logic                w_done_nxt;
    logic                w_gnt0;
    logic                w_gnt1;
    logic                r_rd_pend0;
    logic                r_rd_pend1;
    logic [DATA_W-1:0]   r_rdata0;
    logic [DATA_W-1:0]   r_rdata1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_ptr      <= 1'b0;
            r_cnt      <= '0;
            r_done     <= 1'b0;
            r_rd_pend0 <= 1'b0;
            r_rd_pend1 <= 1'b0;
            r_rdata0   <= '0;
            r_rdata1   <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_ptr      <= w_ptr_nxt;
            r_cnt      <= w_cnt_nxt;
            r_done     <= w_done_nxt;
            r_rd_pend0 <= w_gnt0 & ~req0_we;
            r_rd_pend1 <= w_gnt1 & ~req1_we;
            if (r_rd_pend0) begin
                r_rdata0 <= rf_r_data;
            end
            if (r_rd_pend1) begin
                r_rdata1 <= rf_r_data;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_cnt_nxt   = r_cnt;
        w_done_nxt  = 1'b0;
        w_gnt0      = 1'b0;
        w_gnt1      = 1'b0;
        rf_we       = 1'b0;
        rf_addr     = '0;
        rf_w_data   = '0;
        case (r_state)
            ST_IDLE: begin
                if (clr_start) begin
                    w_state_nxt = ST_CLEAR;
                    w_cnt_nxt   = '0;
                end else if (rst_n) begin
                    // Pointer only breaks ties; a lone requester always wins.
                    if (req0_valid && (!req1_valid || !r_ptr)) begin
                        w_gnt0 = 1'b1;
                    end else if (req1_valid) begin
                        w_gnt1 = 1'b1;
                    end
                    if (w_gnt0) begin
                        rf_we     = req0_we;
                        rf_addr   = req0_addr;
                        rf_w_data = req0_wdata;
                        w_ptr_nxt = 1'b1;
                    end else if (w_gnt1) begin
                        rf_we     = req1_we;
                        rf_addr   = req1_addr;
                        rf_w_data = req1_wdata;
                        w_ptr_nxt = 1'b0;
                    end
                end
            end
            ST_CLEAR: begin
                rf_we     = 1'b1;
                rf_addr   = r_cnt;
                w_cnt_nxt = r_cnt + 1'b1;
                if (r_cnt == c_LAST_ADDR) begin
                    w_state_nxt = ST_IDLE;
                    w_done_nxt  = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign req0_ready  = w_gnt0;
    assign req1_ready  = w_gnt1;
    // Read data is passed straight through in the return cycle, then held.
    assign req0_rvalid = r_rd_pend0;
    assign req1_rvalid = r_rd_pend1;
    assign req0_rdata  = r_rd_pend0 ? rf_r_data : r_rdata0;
    assign req1_rdata  = r_rd_pend1 ? rf_r_data : r_rdata1;
    assign clr_busy    = (r_state == ST_CLEAR);
    assign clr_done    = r_done;

endmodule

`default_nettype wire
